// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and datapath select codes.
// Used by mc_control_fsm and mc_alu_dec.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_REGA  = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_REGB = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to an ALU operation.
module mc_alu_dec
    import mc_control_fsm_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic        op5,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    output alu_ctrl_t   alu_control
);

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        // Only register-register ops use funct7 to select subtract.
                        if (op5 && funct7) alu_control = ALU_SUB;
                        else               alu_control = ALU_ADD;
                    end
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for a multicycle RISC-V style datapath.
// Optional memory wait states are enabled by defining MC_MEM_WAIT_EN (adds the MemReady port).
module mc_control_fsm
    import mc_control_fsm_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  OP,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    input  logic        Zero,
`ifdef MC_MEM_WAIT_EN
    input  logic        MemReady,
`endif
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        InstrDone,
    output logic        Trap
);

    state_t      state, next_state;
    logic        mem_ready;
    logic        adr_src, ir_write, mem_write, reg_write;
    logic        pc_update, branch, instr_done, trap;
    result_src_t result_src;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    imm_src_t    imm_src;
    alu_op_t     alu_op;
    alu_ctrl_t   alu_control;

`ifdef MC_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_update  = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (OP)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECR;
                    OP_ITYPE:     next_state = S_EXECI;
                    OP_JAL:       next_state = S_JAL;
                    OP_BEQ:       next_state = S_BEQ;
                    default:      next_state = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                if (OP == OP_SW) begin
                    imm_src    = IMM_S;
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a  = SRCA_REGA;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                imm_src    = IMM_J;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_REGA;
                alu_op     = ALUOP_SUB;
                imm_src    = IMM_B;
                branch     = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_ERROR: begin
                trap       = 1'b1;
                next_state = S_ERROR;
            end
            default: next_state = S_FETCH;
        endcase
    end

    mc_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .op5         (OP[5]),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (alu_control)
    );

    // The reset value of state is FETCH, whose strobes are active, so strobes are masked by RST directly.
    assign PCWrite    = RST & (pc_update | (branch & Zero));
    assign IRWrite    = RST & ir_write;
    assign MemWrite   = RST & mem_write;
    assign RegWrite   = RST & reg_write;
    assign InstrDone  = RST & instr_done;
    assign Trap       = RST & trap;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ImmSrc     = imm_src;
    assign ALUControl = alu_control;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm; covers the MC_MEM_WAIT_EN build when that macro is defined.
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] OP = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       Zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
    logic       MemReady = 1'b1;
`endif
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, InstrDone, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int errors = 0;
    int checks = 0;

    mc_control_fsm dut (
        .CLK        (CLK),
        .RST        (RST),
        .OP         (OP),
        .funct3     (funct3),
        .funct7     (funct7),
        .Zero       (Zero),
`ifdef MC_MEM_WAIT_EN
        .MemReady   (MemReady),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .InstrDone  (InstrDone),
        .Trap       (Trap)
    );

    always #5 CLK = ~CLK;

    // Field order: PCWrite AdrSrc IRWrite MemWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl InstrDone Trap
    logic [17:0] outs;
    assign outs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Trap};

    localparam logic [17:0] V_RESET     = 18'b0_0_0_0_0_10_00_10_00_000_0_0;
    localparam logic [17:0] V_FETCH     = 18'b1_0_1_0_0_10_00_10_00_000_0_0;
    localparam logic [17:0] V_DECODE    = 18'b0_0_0_0_0_00_01_01_10_000_0_0;
    localparam logic [17:0] V_MEMADR_LW = 18'b0_0_0_0_0_00_10_01_00_000_0_0;
    localparam logic [17:0] V_MEMADR_SW = 18'b0_0_0_0_0_00_10_01_01_000_0_0;
    localparam logic [17:0] V_MEMREAD   = 18'b0_1_0_0_0_00_00_00_00_000_0_0;
    localparam logic [17:0] V_MEMWB     = 18'b0_0_0_0_1_01_00_00_00_000_1_0;
    localparam logic [17:0] V_MEMWRITE  = 18'b0_1_0_1_0_00_00_00_00_000_1_0;
    localparam logic [17:0] V_MEMWR_WT  = 18'b0_1_0_1_0_00_00_00_00_000_0_0;
    localparam logic [17:0] V_EXECR     = 18'b0_0_0_0_0_00_10_00_00_000_0_0;
    localparam logic [17:0] V_EXECI     = 18'b0_0_0_0_0_00_10_01_00_000_0_0;
    localparam logic [17:0] V_ALUWB     = 18'b0_0_0_0_1_00_00_00_00_000_1_0;
    localparam logic [17:0] V_JAL       = 18'b1_0_0_0_0_00_01_10_11_000_0_0;
    localparam logic [17:0] V_BEQ_TAKEN = 18'b1_0_0_0_0_00_10_00_10_001_1_0;
    localparam logic [17:0] V_BEQ_NOT   = 18'b0_0_0_0_0_00_10_00_10_001_1_0;
    localparam logic [17:0] V_ERROR     = 18'b0_0_0_0_0_00_00_00_00_000_0_1;

    // R-type variants: funct3, funct7, expected ALUControl in EXECR
    logic [2:0] r_f3  [6] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b001};
    logic       r_f7  [6] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
    logic [2:0] r_alu [6] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b101, 3'b000};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_now(input string tag, input logic [17:0] exp);
        #1;
        check(tag, outs, exp);
    endtask

    task automatic start_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z);
        tick();
        OP = op; funct3 = f3; funct7 = f7; Zero = z;
        expect_now({tag, "_fetch"}, V_FETCH);
        tick();
        expect_now({tag, "_decode"}, V_DECODE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        #12;
        expect_now("reset_hold", V_RESET);
        @(negedge CLK);
        RST = 1'b1;
        OP  = 7'b0000011;

        // lw straight after reset: five states
        expect_now("lw_fetch", V_FETCH);
        tick(); expect_now("lw_decode", V_DECODE);
        tick(); expect_now("lw_memadr", V_MEMADR_LW);
        tick(); expect_now("lw_memread", V_MEMREAD);
        tick(); expect_now("lw_memwb", V_MEMWB);

        start_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
        tick(); expect_now("sw_memadr", V_MEMADR_SW);
        tick(); expect_now("sw_memwrite", V_MEMWRITE);

        for (int i = 0; i < 6; i++) begin
            start_instr("rtype", 7'b0110011, r_f3[i], r_f7[i], 1'b0);
            tick(); expect_now("rtype_execr", {V_EXECR[17:5], r_alu[i], V_EXECR[1:0]});
            tick(); expect_now("rtype_aluwb", V_ALUWB);
        end

        start_instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0);
        tick(); expect_now("addi_execi", V_EXECI);
        tick(); expect_now("addi_aluwb", V_ALUWB);

        start_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
        tick(); expect_now("jal_jal", V_JAL);
        tick(); expect_now("jal_aluwb", V_ALUWB);

        start_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1);
        tick(); expect_now("beq_taken", V_BEQ_TAKEN);
        start_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0);
        tick(); expect_now("beq_not_taken", V_BEQ_NOT);

        // Reset during MEMREAD aborts the load
        start_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0);
        tick(); expect_now("lwab_memadr", V_MEMADR_LW);
        tick(); expect_now("lwab_memread", V_MEMREAD);
        RST = 1'b0;
        expect_now("lwab_reset_now", V_RESET);
        tick(); expect_now("lwab_reset_edge", V_RESET);
        @(negedge CLK);
        RST = 1'b1;
        expect_now("lwab_refetch", V_FETCH);
        tick(); expect_now("lwab_decode", V_DECODE);
        tick(); expect_now("lwab_memadr2", V_MEMADR_LW);
        tick(); expect_now("lwab_memread2", V_MEMREAD);
        tick(); expect_now("lwab_memwb", V_MEMWB);

`ifdef MC_MEM_WAIT_EN
        // FETCH stalls on MemReady
        tick();
        OP = 7'b0100011;
        MemReady = 1'b0;
        expect_now("wait_fetch0", V_RESET);
        tick(); expect_now("wait_fetch1", V_RESET);
        MemReady = 1'b1;
        expect_now("wait_fetch_rdy", V_FETCH);
        tick(); expect_now("wait_decode", V_DECODE);
        tick(); expect_now("wait_memadr", V_MEMADR_SW);
        tick();
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_now("wait_memwrite_stall", V_MEMWR_WT);
            tick();
        end
        MemReady = 1'b1;
        expect_now("wait_memwrite_done", V_MEMWRITE);
`endif

        // Illegal opcode traps until reset
        start_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(); expect_now("trap_hold", V_ERROR);
        end
        RST = 1'b0;
        expect_now("trap_reset", V_RESET);
        @(negedge CLK);
        RST = 1'b1;
        OP  = 7'b0110011;
        expect_now("trap_refetch", V_FETCH);
        tick(); expect_now("trap_redecode", V_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 No parameters; all encodings are fixed constants.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous active-low reset.
REQ-004 OP  input  7  opcode from the instruction register.
REQ-005 funct3  input  3  instruction bits [14:12].
REQ-006 funct7  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 MemReady  input  1  memory access complete; present only with MC_MEM_WAIT_EN.
REQ-009 PCWrite  output  1  PC register enable.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
REQ-011 IRWrite  output  1  instruction register enable.
REQ-012 MemWrite  output  1  data memory write strobe.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 ResultSrc  output  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-015 ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RegA.
REQ-016 ALUSrcB  output  2  ALU B select: 00 = RegB, 01 = Imm, 10 = constant 4.
REQ-017 ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-018 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-019 InstrDone  output  1  high for exactly one cycle when an instruction completes.
REQ-020 Trap  output  1  illegal opcode detected; sticky until reset.

Function
REQ-021 The block SHALL be a Moore FSM. All outputs are decoded from the state register, except PCWrite, which is PCUpdate OR (Branch AND Zero). Any output not listed for a state is 0.
REQ-022 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state is DECODE.
REQ-023 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=10. Next state by OP:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1101111 -> JAL
- 1100011 -> BEQ
- any other value -> ERROR
REQ-024 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=00 for lw and 01 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
REQ-025 MEMREAD: ResultSrc=00, AdrSrc=1. Next state is MEMWB.
REQ-026 MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
REQ-027 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is FETCH.
REQ-028 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
REQ-029 EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, ImmSrc=00. Next state is ALUWB.
REQ-030 ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
REQ-031 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, ImmSrc=11, PCUpdate=1. Next state is ALUWB.
REQ-032 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, ImmSrc=10, Branch=1. Next state is FETCH.
REQ-033 ERROR: all outputs 0 except Trap=1. The FSM stays in ERROR until reset.
REQ-034 ALU decoding:
- ALUOp=00 -> add; ALUOp=01 -> sub.
- ALUOp=10 -> decode funct3: 000 gives sub if (OP[5] AND funct7), else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-035 InstrDone SHALL be 1 in the final cycle of MEMWB, MEMWRITE, ALUWB and BEQ.
REQ-036 Latency without wait states, in cycles: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
REQ-037 OP, funct3 and funct7 SHALL be sampled only in DECODE and MEMADR (OP) and in EXECR/EXECI (funct3, funct7); they are don't-care in all other states.

Reset
REQ-038 While RST=0 the state SHALL be FETCH and IRWrite, PCWrite, MemWrite, RegWrite, InstrDone and Trap SHALL be 0. All other outputs take their FETCH values.
REQ-039 Reset asserted mid-instruction SHALL abort the instruction immediately. The first rising edge after release SHALL execute a normal FETCH.

Configuration
REQ-040 With MC_MEM_WAIT_EN defined, the MemReady port exists and the following apply:
- FETCH, MEMREAD and MEMWRITE hold their state while MemReady=0.
- In FETCH, IRWrite and PCWrite assert only in the cycle where MemReady=1.
- MemWrite stays asserted for the whole of MEMWRITE.
- InstrDone in MEMWRITE asserts only when MemReady=1.
REQ-041 Without MC_MEM_WAIT_EN, the MemReady port is absent and every state lasts exactly one cycle.

Structure
REQ-042 A shared package SHALL hold the state enumeration, the opcode constants, and the ALUOp, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and ALUControl encodings.
REQ-043 ALU decoding (REQ-034) SHALL be a combinational sub-module, mc_alu_dec, instantiated once.

Verification
REQ-044 lw, OP=0000011 after reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 in cycle 5 only; InstrDone in cycle 5.
REQ-045 beq, OP=1100011: with Zero=1 in cycle 3 -> PCWrite=1 in cycle 3; with Zero=0 -> PCWrite=0 in cycle 3.
REQ-046 R-type sub, OP=0110011, funct3=000, funct7=1 -> ALUControl=001 in EXECR. Repeat with OP=0010011 (addi), funct7=1 -> ALUControl=000.
REQ-047 OP=1111111 -> ERROR with Trap=1 held for 10 cycles; RST pulse -> Trap=0, then a normal FETCH.
REQ-048 With MC_MEM_WAIT_EN, sw with MemReady low for 3 cycles -> MemWrite high for 4 cycles and one InstrDone pulse; with MemReady low in FETCH -> IRWrite=0 until MemReady=1.
REQ-049 RST asserted during MEMREAD -> all strobes 0 immediately; after release the FSM restarts from FETCH.
